eh2_dec_gpr_wb_arb: RTL and testbench

- Writeback scheduler in front of the per-thread GPR file's four write ports (waddr0..3/wtid0..3/wen0..3/wd0..3).
- Ports 0/1 carry the two in-order pipe writebacks (i0, i1), which never stall.
- Ports 2/3 are shared round-robin among NREQ slow writeback requesters (non-blocking load returns, divider, etc.) with a valid/ready handshake.
- Guarantees that no two ports write the same (tid, addr) in one cycle. All port outputs are registered.

---
 rtl/eh2_pkg.sv | 43 ++++
 rtl/eh2_dec_rr_pick2.sv | 48 ++++
 rtl/eh2_dec_gpr_wb_arb.sv | 152 +++++++++++++++
 tb/tb_eh2_dec_gpr_wb_arb.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eh2_pkg.sv
// Shared EH2 decode-stage types: GPR writeback packet, slow-port count,
// and small helpers used by the writeback scheduler.
package eh2_pkg;

    typedef struct packed {
        logic        wen;
        logic        wtid;
        logic [4:0]  waddr;
        logic [31:0] wd;
    } eh2_gpr_wb_pkt_t;

    localparam int GPR_WB_SLOW_PORTS = 2;

    function automatic logic gpr_same_target(
        input logic       tid_a,
        input logic [4:0] addr_a,
        input logic       tid_b,
        input logic [4:0] addr_b
    );
        return (tid_a == tid_b) && (addr_a == addr_b);
    endfunction

    // Fields are zeroed when the packet does not write, keeping idle ports quiet.
    function automatic eh2_gpr_wb_pkt_t gpr_wb_pkt(
        input logic        wen,
        input logic        wtid,
        input logic [4:0]  waddr,
        input logic [31:0] wd
    );
        eh2_gpr_wb_pkt_t pkt;
        pkt = '0;
        if (wen) begin
            pkt.wen   = 1'b1;
            pkt.wtid  = wtid;
            pkt.waddr = waddr;
            pkt.wd    = wd;
        end else begin
            pkt = '0;
        end
        return pkt;
    endfunction

endpackage

// File: rtl/eh2_dec_rr_pick2.sv
// Rotating-priority picker that grants up to two eligible requesters per cycle,
// never granting two requesters aimed at the same register.
module eh2_dec_rr_pick2
    import eh2_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int RRW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]            elig,
    input  logic [RRW-1:0]             ptr,
    input  logic [NREQ-1:0][NREQ-1:0]  same,
    output logic [NREQ-1:0]            gnt0,
    output logic [NREQ-1:0]            gnt1,
    output logic [RRW-1:0]             next_ptr
);

    logic           have0;
    logic           have1;
    logic [RRW-1:0] first;
    logic [RRW-1:0] idx;

    // Walk the requesters starting at ptr; the pointer follows the last grant.
    always_comb begin
        gnt0     = '0;
        gnt1     = '0;
        next_ptr = ptr;
        have0    = 1'b0;
        have1    = 1'b0;
        first    = ptr;
        idx      = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = RRW'((int'(ptr) + k) % NREQ);
            if (elig[idx] && !have0) begin
                have0     = 1'b1;
                first     = idx;
                gnt0[idx] = 1'b1;
                next_ptr  = RRW'((int'(idx) + 1) % NREQ);
            end else if (elig[idx] && have0 && !have1 && !same[first][idx]) begin
                have1     = 1'b1;
                gnt1[idx] = 1'b1;
                next_ptr  = RRW'((int'(idx) + 1) % NREQ);
            end else begin
                have1 = have1;
            end
        end
    end

endmodule

// File: rtl/eh2_dec_gpr_wb_arb.sv
// GPR writeback scheduler: pipe writebacks on ports 0/1, round-robin slow
// requesters on ports 2/3, with same-register collisions resolved before the flops.
module eh2_dec_gpr_wb_arb
    import eh2_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int RRW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             pipe_wen,
    input  logic [1:0][4:0]        pipe_waddr,
    input  logic [1:0]             pipe_wtid,
    input  logic [1:0][31:0]       pipe_wd,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0][4:0]   req_waddr,
    input  logic [NREQ-1:0]        req_wtid,
    input  logic [NREQ-1:0][31:0]  req_wd,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        req_squash,
    output logic [4:0]             waddr0,
    output logic [4:0]             waddr1,
    output logic [4:0]             waddr2,
    output logic [4:0]             waddr3,
    output logic                   wtid0,
    output logic                   wtid1,
    output logic                   wtid2,
    output logic                   wtid3,
    output logic                   wen0,
    output logic                   wen1,
    output logic                   wen2,
    output logic                   wen3,
    output logic [31:0]            wd0,
    output logic [31:0]            wd1,
    output logic [31:0]            wd2,
    output logic [31:0]            wd3
);

    localparam int NPORT = 2 + GPR_WB_SLOW_PORTS;

    logic [1:0]                pipe_act;
    logic                      pipe_dup;
    logic [NREQ-1:0]           hit_pipe;
    logic [NREQ-1:0]           is_x0;
    logic [NREQ-1:0]           elig;
    logic [NREQ-1:0][NREQ-1:0] same;
    logic [NREQ-1:0]           gnt0;
    logic [NREQ-1:0]           gnt1;
    logic [RRW-1:0]            rr_ptr;
    logic [RRW-1:0]            next_ptr;
    eh2_gpr_wb_pkt_t           port_nxt [NPORT];
    eh2_gpr_wb_pkt_t           port_r   [NPORT];

    // Pipe writes to x0 are dropped; a same-target i0 loses to the younger i1.
    always_comb begin
        pipe_act[0] = pipe_wen[0] && (pipe_waddr[0] != 5'd0);
        pipe_act[1] = pipe_wen[1] && (pipe_waddr[1] != 5'd0);
        pipe_dup    = pipe_act[0] && pipe_act[1] &&
                      gpr_same_target(pipe_wtid[0], pipe_waddr[0], pipe_wtid[1], pipe_waddr[1]);
    end

    // Classify each slow request and build the pairwise same-target matrix.
    always_comb begin
        is_x0    = '0;
        hit_pipe = '0;
        same     = '0;
        for (int i = 0; i < NREQ; i++) begin
            is_x0[i]    = req_valid[i] && (req_waddr[i] == 5'd0);
            hit_pipe[i] = req_valid[i] && !is_x0[i] &&
                ((pipe_act[0] && gpr_same_target(req_wtid[i], req_waddr[i], pipe_wtid[0], pipe_waddr[0])) ||
                 (pipe_act[1] && gpr_same_target(req_wtid[i], req_waddr[i], pipe_wtid[1], pipe_waddr[1])));
            for (int j = 0; j < NREQ; j++) begin
                same[i][j] = gpr_same_target(req_wtid[i], req_waddr[i], req_wtid[j], req_waddr[j]);
            end
        end
    end

    assign elig = req_valid & ~hit_pipe & ~is_x0;

    eh2_dec_rr_pick2 #(
        .NREQ (NREQ),
        .RRW  (RRW)
    ) u_pick2 (
        .elig     (elig),
        .ptr      (rr_ptr),
        .same     (same),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .next_ptr (next_ptr)
    );

    // Squashed and x0 requests complete immediately without consuming a port.
    always_comb begin
        if (rst) begin
            req_ready  = '0;
            req_squash = '0;
        end else begin
            req_ready  = gnt0 | gnt1 | hit_pipe | is_x0;
            req_squash = hit_pipe;
        end
    end

    // Next-cycle contents of the four write ports.
    always_comb begin
        port_nxt[0] = gpr_wb_pkt(pipe_act[0] && !pipe_dup, pipe_wtid[0], pipe_waddr[0], pipe_wd[0]);
        port_nxt[1] = gpr_wb_pkt(pipe_act[1], pipe_wtid[1], pipe_waddr[1], pipe_wd[1]);
        port_nxt[2] = '0;
        port_nxt[3] = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt0[i]) begin
                port_nxt[2] = gpr_wb_pkt(1'b1, req_wtid[i], req_waddr[i], req_wd[i]);
            end else if (gnt1[i]) begin
                port_nxt[3] = gpr_wb_pkt(1'b1, req_wtid[i], req_waddr[i], req_wd[i]);
            end else begin
                port_nxt[2] = port_nxt[2];
            end
        end
    end

    // Output pipeline and round-robin pointer; reset drops in-flight writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NPORT; p++) begin
                port_r[p] <= '0;
            end
            rr_ptr <= '0;
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                port_r[p] <= port_nxt[p];
            end
            rr_ptr <= next_ptr;
        end
    end

    assign wen0   = port_r[0].wen;
    assign wtid0  = port_r[0].wtid;
    assign waddr0 = port_r[0].waddr;
    assign wd0    = port_r[0].wd;
    assign wen1   = port_r[1].wen;
    assign wtid1  = port_r[1].wtid;
    assign waddr1 = port_r[1].waddr;
    assign wd1    = port_r[1].wd;
    assign wen2   = port_r[2].wen;
    assign wtid2  = port_r[2].wtid;
    assign waddr2 = port_r[2].waddr;
    assign wd2    = port_r[2].wd;
    assign wen3   = port_r[3].wen;
    assign wtid3  = port_r[3].wtid;
    assign waddr3 = port_r[3].waddr;
    assign wd3    = port_r[3].wd;

endmodule

// File: tb/tb_eh2_dec_gpr_wb_arb.sv
// Scoreboard bench for eh2_dec_gpr_wb_arb: directed scenarios plus random traffic
// checked against a queue-based reference model of the writeback rules.
module tb_eh2_dec_gpr_wb_arb;
    import eh2_pkg::*;

    localparam int NREQ = 4;

    typedef eh2_gpr_wb_pkt_t [3:0] ports_t;
    typedef struct {
        ports_t p;
        bit     rz;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            pipe_wen;
    logic [1:0][4:0]       pipe_waddr;
    logic [1:0]            pipe_wtid;
    logic [1:0][31:0]      pipe_wd;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][4:0]  req_waddr;
    logic [NREQ-1:0]       req_wtid;
    logic [NREQ-1:0][31:0] req_wd;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       req_squash;
    logic [4:0]            waddr0, waddr1, waddr2, waddr3;
    logic                  wtid0, wtid1, wtid2, wtid3;
    logic                  wen0, wen1, wen2, wen3;
    logic [31:0]           wd0, wd1, wd2, wd3;

    eh2_dec_gpr_wb_arb #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wtid(pipe_wtid), .pipe_wd(pipe_wd),
        .req_valid(req_valid), .req_waddr(req_waddr), .req_wtid(req_wtid), .req_wd(req_wd),
        .req_ready(req_ready), .req_squash(req_squash),
        .waddr0(waddr0), .waddr1(waddr1), .waddr2(waddr2), .waddr3(waddr3),
        .wtid0(wtid0), .wtid1(wtid1), .wtid2(wtid2), .wtid3(wtid3),
        .wen0(wen0), .wen1(wen1), .wen2(wen2), .wen3(wen3),
        .wd0(wd0), .wd1(wd1), .wd2(wd2), .wd3(wd3)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   mptr     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic eh2_gpr_wb_pkt_t mk(input logic w, input logic t, input logic [4:0] a, input logic [31:0] d);
        eh2_gpr_wb_pkt_t x;
        x.wen = w; x.wtid = t; x.waddr = a; x.wd = d;
        return x;
    endfunction

    // Reference model: scan requesters in rotated order applying the writeback rules.
    task automatic model(output logic [NREQ-1:0] rdy, output logic [NREQ-1:0] sq, output ports_t p);
        int granted[$];
        bit pact[2];
        int i;
        bit clash;
        rdy = '0; sq = '0; p = '0;
        if (rst) begin
            mptr = 0;
            return;
        end
        for (int q = 0; q < 2; q++) pact[q] = pipe_wen[q] && (pipe_waddr[q] != 5'd0);
        if (pact[1]) p[1] = mk(1'b1, pipe_wtid[1], pipe_waddr[1], pipe_wd[1]);
        if (pact[0] && !(pact[1] && pipe_wtid[0] == pipe_wtid[1] && pipe_waddr[0] == pipe_waddr[1]))
            p[0] = mk(1'b1, pipe_wtid[0], pipe_waddr[0], pipe_wd[0]);
        for (int k = 0; k < NREQ; k++) begin
            i = (mptr + k) % NREQ;
            clash = 1'b0;
            if (!req_valid[i]) continue;
            if (req_waddr[i] == 5'd0) begin
                rdy[i] = 1'b1;
                continue;
            end
            for (int q = 0; q < 2; q++)
                if (pact[q] && pipe_wtid[q] == req_wtid[i] && pipe_waddr[q] == req_waddr[i]) clash = 1'b1;
            if (clash) begin
                rdy[i] = 1'b1;
                sq[i]  = 1'b1;
                continue;
            end
            foreach (granted[g])
                if (req_wtid[granted[g]] == req_wtid[i] && req_waddr[granted[g]] == req_waddr[i]) clash = 1'b1;
            if (!clash && granted.size() < 2) begin
                rdy[i] = 1'b1;
                granted.push_back(i);
            end
        end
        if (granted.size() > 0) begin
            p[2] = mk(1'b1, req_wtid[granted[0]], req_waddr[granted[0]], req_wd[granted[0]]);
            mptr = (granted[granted.size()-1] + 1) % NREQ;
        end
        if (granted.size() > 1)
            p[3] = mk(1'b1, req_wtid[granted[1]], req_waddr[granted[1]], req_wd[granted[1]]);
    endtask

    task automatic new_req(input int i);
        req_valid[i] = 1'b1;
        req_waddr[i] = 5'($urandom_range(0, 7));
        req_wtid[i]  = 1'($urandom_range(0, 1));
        req_wd[i]    = $urandom;
    endtask

    // One cycle: mode 0 drops served requests, 1 reissues them, 2 is random traffic.
    task automatic step(input int mode);
        logic [NREQ-1:0] rdy, sq;
        ports_t p;
        exp_t e;
        #1;
        model(rdy, sq, p);
        check("req_ready", 64'(req_ready), 64'(rdy));
        check("req_squash", 64'(req_squash), 64'(sq));
        e.p = p; e.rz = rst;
        exp_q.push_back(e);
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && rdy[i]) begin
                if (mode == 0) req_valid[i] = 1'b0;
                else if (mode == 1) req_wd[i] = req_wd[i] + 32'd1;
                else if ($urandom_range(0, 1) == 1) new_req(i);
                else req_valid[i] = 1'b0;
            end else if (!req_valid[i] && mode == 2 && $urandom_range(0, 1) == 1) begin
                new_req(i);
            end
        end
        if (mode == 0) begin
            pipe_wen = 2'b00;
        end else if (mode == 2) begin
            for (int q = 0; q < 2; q++) begin
                pipe_wen[q]   = 1'($urandom_range(0, 1));
                pipe_waddr[q] = 5'($urandom_range(0, 7));
                pipe_wtid[q]  = 1'($urandom_range(0, 1));
                pipe_wd[q]    = $urandom;
            end
        end
    endtask

    // Monitor: port invariants every cycle, then compare against the scoreboard head.
    initial begin
        exp_t   e;
        ports_t a;
        forever begin
            @(posedge clk);
            #1;
            a[0] = mk(wen0, wtid0, waddr0, wd0);
            a[1] = mk(wen1, wtid1, waddr1, wd1);
            a[2] = mk(wen2, wtid2, waddr2, wd2);
            a[3] = mk(wen3, wtid3, waddr3, wd3);
            for (int x = 0; x < 4; x++) begin
                if (a[x].wen === 1'b1) check($sformatf("x0_write_port%0d", x), 64'(a[x].waddr == 5'd0), 64'd0);
                for (int y = x + 1; y < 4; y++)
                    if (a[x].wen === 1'b1 && a[y].wen === 1'b1)
                        check($sformatf("collision_p%0d_p%0d", x, y),
                              64'(a[x].wtid == a[y].wtid && a[x].waddr == a[y].waddr), 64'd0);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int x = 0; x < 4; x++) begin
                    check($sformatf("wen%0d", x), 64'(a[x].wen), 64'(e.p[x].wen));
                    if (e.p[x].wen || e.rz) begin
                        check($sformatf("wtid%0d", x), 64'(a[x].wtid), 64'(e.p[x].wtid));
                        check($sformatf("waddr%0d", x), 64'(a[x].waddr), 64'(e.p[x].waddr));
                        check($sformatf("wd%0d", x), 64'(a[x].wd), 64'(e.p[x].wd));
                    end
                end
            end
        end
    end

    initial begin
        int waits;
        // Reset with every input active, then held round-robin traffic.
        rst = 1'b1;
        pipe_wen = 2'b11; pipe_wtid = 2'b00;
        pipe_waddr[0] = 5'd10; pipe_waddr[1] = 5'd11;
        pipe_wd[0] = 32'h1111; pipe_wd[1] = 32'h2222;
        req_valid = 4'b1111; req_wtid = 4'b0000;
        for (int i = 0; i < NREQ; i++) begin
            req_waddr[i] = 5'(i + 1);
            req_wd[i]    = 32'h100 * 32'(i + 1);
        end
        step(1);
        step(1);
        rst = 1'b0;
        step(1);
        check("rr1_waddr2", 64'(waddr2), 64'd1);
        check("rr1_waddr3", 64'(waddr3), 64'd2);
        step(1);
        check("rr2_waddr2", 64'(waddr2), 64'd3);
        check("rr2_waddr3", 64'(waddr3), 64'd4);
        step(1);
        check("rr3_waddr2", 64'(waddr2), 64'd1);
        check("rr3_waddr3", 64'(waddr3), 64'd2);
        req_valid = '0; pipe_wen = 2'b00;
        step(0);

        // Pipe same-target: i1 wins.
        pipe_wen = 2'b11; pipe_wtid = 2'b00;
        pipe_waddr[0] = 5'd5; pipe_waddr[1] = 5'd5;
        pipe_wd[0] = 32'hAAAA; pipe_wd[1] = 32'hBBBB;
        step(0);
        check("dup_wen0", 64'(wen0), 64'd0);
        check("dup_wen1", 64'(wen1), 64'd1);
        check("dup_waddr1", 64'(waddr1), 64'd5);
        check("dup_wd1", 64'(wd1), 64'hBBBB);

        // Squash against pipe i1.
        pipe_wen = 2'b10; pipe_wtid[1] = 1'b1; pipe_waddr[1] = 5'd7; pipe_wd[1] = 32'h7777;
        req_valid[2] = 1'b1; req_wtid[2] = 1'b1; req_waddr[2] = 5'd7; req_wd[2] = 32'hDEAD;
        step(0);

        // Slow same-target from a fresh pointer.
        rst = 1'b1;
        step(0);
        rst = 1'b0;
        req_valid = 4'b0011; req_wtid[0] = 1'b0; req_wtid[1] = 1'b0;
        req_waddr[0] = 5'd9; req_waddr[1] = 5'd9;
        req_wd[0] = 32'h9000; req_wd[1] = 32'h9001;
        step(0);
        step(0);

        // x0 completion alongside two real grants.
        req_valid = 4'b1011;
        req_waddr[3] = 5'd0; req_wd[3] = 32'h3333;
        req_waddr[0] = 5'd12; req_waddr[1] = 5'd13;
        step(0);
        step(0);

        // Random traffic with occasional mid-operation reset.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            step(2);
        end
        rst = 1'b0;
        req_valid = '0; pipe_wen = 2'b00;

        waits = 0;
        while (exp_q.size() > 0 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending expectations", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
